// File: rtl/inst_ram_loader.sv
// Program loader for the 256x8 instruction RAM.
// Streams bytes into RAM from address 0 and holds the CPU until loaded.
module inst_ram_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0] ONE = 1;
  localparam logic [ADDR_W:0] LAST_IDX =
    (ADDR_W+1)'(DEPTH - 1);

  state_t state;
  logic   settled;
  logic   xfer;
  logic   last_slot;

  assign byte_ready = (state == S_LOAD);
  assign xfer       = byte_valid & byte_ready;
  assign last_slot  = (byte_count == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settled    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_count <= '0;
      checksum   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we <= xfer;
      if (xfer) begin
        mem_addr   <= byte_count[ADDR_W-1:0];
        mem_wdata  <= byte_in;
        byte_count <= byte_count + ONE;
        checksum   <= checksum ^ byte_in;
      end
      unique case (state)
        S_LOAD: begin
          if (xfer && byte_last) begin
            state   <= S_DONE;
            done    <= 1'b1;
            settled <= 1'b0;
          end else if (xfer && last_slot) begin
            state <= S_ERR;
            error <= 1'b1;
          end
        end
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LOAD;
            byte_count <= '0;
            checksum   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            settled    <= 1'b0;
          end else if (state == S_DONE) begin
            // last byte lands in RAM one edge into DONE; release after it
            settled <= 1'b1;
            if (settled) cpu_hold <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Bench for inst_ram_loader: spec-level model checked every cycle,
// plus directed loads with literal expectations.
module tb_inst_ram_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [8:0] byte_count;
  logic [7:0] checksum;
  logic       cpu_hold;
  logic       done;
  logic       error;

  inst_ram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .byte_count(byte_count),
    .checksum(checksum), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  int checks = 0;
  int errors = 0;
  bit clk_en = 0;
  bit chk_en = 0;

  initial begin
    clk = 0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 loaded, 3 overflowed.
  int         m_ph;
  int         m_age;
  int         m_cnt;
  logic [7:0] m_sum;
  logic       m_xfer;
  logic [7:0] m_addr;
  logic [7:0] m_wd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_age <= 0; m_cnt <= 0; m_sum <= 0;
      m_xfer <= 0; m_addr <= 0; m_wd <= 0;
    end else begin
      m_xfer <= byte_valid && m_ph == 1;
      if (byte_valid && m_ph == 1) begin
        m_addr <= 8'(m_cnt);
        m_wd   <= byte_in;
        m_cnt  <= m_cnt + 1;
        m_sum  <= m_sum ^ byte_in;
        if (byte_last) begin
          m_ph  <= 2;
          m_age <= 0;
        end else if (m_cnt + 1 == 256) begin
          m_ph <= 3;
        end
      end else if (start && m_ph != 1) begin
        m_ph  <= 1;
        m_cnt <= 0;
        m_sum <= 0;
      end else if (m_ph == 2 && m_age < 3) begin
        m_age <= m_age + 1;
      end
    end
  end

  logic [7:0] ram [256];
  int         npulse;

  always @(negedge clk) begin
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      npulse++;
    end
    if (chk_en) begin
      chk("byte_ready", 32'(byte_ready), 32'(m_ph == 1));
      chk("mem_we", 32'(mem_we), 32'(m_xfer));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
      chk("byte_count", 32'(byte_count), 32'(m_cnt));
      chk("checksum", 32'(checksum), 32'(m_sum));
      chk("cpu_hold", 32'(cpu_hold),
          32'(!(m_ph == 2 && m_age >= 2)));
      chk("done", 32'(done), 32'(m_ph == 2));
      chk("error", 32'(error), 32'(m_ph == 3));
    end
  end

  logic [7:0] prog[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic send(input bit last, input bit gaps);
    int i = 0;
    int budget = 0;
    while (i < prog.size() && budget < 3000) begin
      byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_in    = prog[i];
      byte_last  = last && (i == prog.size() - 1);
      tick();
      if (m_xfer) i++;
      budget++;
    end
    byte_valid = 0;
    byte_last  = 0;
    chk("send_budget", 32'(i), 32'(prog.size()));
  endtask

  task automatic chk_ram(input string name);
    for (int k = 0; k < prog.size(); k++)
      chk(name, 32'(ram[k]), 32'(prog[k]));
  endtask

  initial begin
    rst_n = 1; start = 0; byte_in = 0;
    byte_valid = 0; byte_last = 0; npulse = 0;
    #3 rst_n = 0;
    #2;
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_count", 32'(byte_count), 0);
    chk("rst_sum", 32'(checksum), 0);
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    clk_en = 1;
    tick(); tick();
    rst_n = 1;
    chk_en = 1;
    tick();

    // basic load of 32'hDB000001
    prog = '{8'hDB, 8'h00, 8'h00, 8'h01};
    npulse = 0;
    do_start();
    send(1, 0);
    chk("basic_done", 32'(done), 1);
    chk("basic_count", 32'(byte_count), 4);
    chk("basic_sum", 32'(checksum), 32'h DA);
    chk("basic_hold_n", 32'(cpu_hold), 1);
    tick();
    chk("basic_hold_n1", 32'(cpu_hold), 1);
    tick();
    chk("basic_hold_n2", 32'(cpu_hold), 0);
    chk("basic_pulses", 32'(npulse), 4);
    chk_ram("basic_ram");

    // 36 bytes with random valid gaps
    prog = {};
    for (int k = 0; k < 36; k++) prog.push_back(8'(k * 7 + 3));
    npulse = 0;
    do_start();
    send(1, 1);
    tick(); tick();
    chk("gap_pulses", 32'(npulse), 36);
    chk("gap_count", 32'(byte_count), 36);
    chk_ram("gap_ram");

    // overflow: 256 bytes with no last
    prog = {};
    for (int k = 0; k < 256; k++) prog.push_back(8'(k ^ 8'hC3));
    npulse = 0;
    do_start();
    send(0, 0);
    chk("ovf_error", 32'(error), 1);
    chk("ovf_ready", 32'(byte_ready), 0);
    chk("ovf_hold", 32'(cpu_hold), 1);
    byte_valid = 1; byte_in = 8'hEE;
    tick(); tick(); tick();
    byte_valid = 0;
    chk("ovf_pulses", 32'(npulse), 256);
    chk("ovf_count", 32'(byte_count), 256);
    chk_ram("ovf_ram");

    // exact fill: last on byte 256
    prog = {};
    for (int k = 0; k < 256; k++) prog.push_back(8'(k ^ 8'h5A));
    npulse = 0;
    do_start();
    send(1, 0);
    chk("fill_done", 32'(done), 1);
    chk("fill_error", 32'(error), 0);
    chk("fill_count", 32'(byte_count), 256);
    tick(); tick();
    chk("fill_hold", 32'(cpu_hold), 0);
    chk_ram("fill_ram");

    // abort mid-load, then reload
    prog = {};
    for (int k = 0; k < 10; k++) prog.push_back(8'(k + 8'h90));
    npulse = 0;
    do_start();
    send(0, 0);
    rst_n = 0;
    tick(); tick(); tick();
    chk("abort_pulses", 32'(npulse), 9);
    chk("abort_count", 32'(byte_count), 0);
    rst_n = 1;
    tick();
    prog = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_start();
    send(1, 0);
    chk("reload_count", 32'(byte_count), 4);
    chk("reload_sum", 32'(checksum), 32'h08);
    tick(); tick();
    chk_ram("reload_ram");

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
